// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency memory between the
// instruction-fetch (IF) and data (MEM) stages of the pipeline.
//
// A four-state FSM (IDLE -> ISSUE -> WAIT -> DONE) serialises accesses.
// MEM has priority, but when both stages request and the previous grant
// went to MEM, IF wins, so neither side can starve the other.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   hlt                CPU halted; new IF requests are ignored
//   if_req/if_addr     fetch request and address, held until if_done
//   if_rdata/if_done   fetched word (registered) and completion pulse
//   stall_if           if_req & ~if_done (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata
//                      data request, held until mem_done
//   mem_rdata/mem_done load data (registered) and completion pulse
//   stall_mem          mem_req & ~mem_done (combinational)
//   ram_en/ram_we/ram_addr/ram_wdata
//                      registered memory strobe, write enable, address, data
//   ram_rdata          memory read data, valid LATENCY cycles after ram_en
//   conflict_cnt       saturating count of cycles with both sides waiting
module mem_arbiter #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hlt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          stall_if,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          stall_mem,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam int unsigned CW = 4;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          last_mem;   // last grant went to MEM
  logic          win_mem;    // current access belongs to MEM

  logic if_elig_c;
  logic mem_elig_c;
  logic pick_mem_c;
  logic conflict_c;

  // Eligibility and arbitration: MEM first, unless MEM had the last grant.
  assign if_elig_c  = if_req & ~hlt;
  assign mem_elig_c = mem_req;
  assign pick_mem_c = mem_elig_c & (~if_elig_c | ~last_mem);

  // Both sides waiting on the memory in this cycle.
  assign conflict_c = (if_elig_c & ~if_done) & (mem_req & ~mem_done);

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  // Arbiter FSM with registered memory-side and requester-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      last_mem     <= 1'b0;
      win_mem      <= 1'b0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      if_rdata     <= '0;
      mem_rdata    <= '0;
      if_done      <= 1'b0;
      mem_done     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      ram_en   <= 1'b0;
      if_done  <= 1'b0;
      mem_done <= 1'b0;

      if (conflict_c && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (if_elig_c || mem_elig_c) begin
            state   <= ISSUE;
            ram_en  <= 1'b1;
            win_mem <= pick_mem_c;
            if (pick_mem_c) begin
              ram_addr  <= mem_addr;
              ram_we    <= mem_we;
              ram_wdata <= mem_wdata;
            end else begin
              // Fetches never write; ram_wdata keeps its old value.
              ram_addr <= if_addr;
              ram_we   <= 1'b0;
            end
          end
        end

        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= CW'(LATENCY);
          last_mem <= win_mem;
        end

        WAIT: begin
          if (wait_cnt == CW'(1)) begin
            // ram_rdata is valid in this last WAIT cycle.
            state    <= DONE;
            wait_cnt <= '0;
            if (win_mem) begin
              mem_done <= 1'b1;
              if (!ram_we) begin
                mem_rdata <= ram_rdata;
              end
            end else begin
              if_done  <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// timing/arbitration model. A second instance with both requests tied high
// exercises conflict counter saturation.
module tb_mem_arbiter;

  localparam int L  = 2;
  localparam int L2 = 15;

  logic        clk;
  logic        rst_n;
  logic        rst2_n;
  logic        hlt;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        stall_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        stall_mem;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [15:0] conflict_cnt;

  logic [15:0] s_if_rdata, s_mem_rdata, s_ram_addr, s_ram_wdata, s_cnt;
  logic        s_if_done, s_stall_if, s_mem_done, s_stall_mem, s_ram_en, s_ram_we;

  mem_arbiter #(.LATENCY(L), .AW(16), .DW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .hlt(hlt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .stall_if(stall_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .conflict_cnt(conflict_cnt)
  );

  mem_arbiter #(.LATENCY(L2), .AW(16), .DW(16)) u_sat (
    .clk(clk), .rst_n(rst2_n), .hlt(1'b0),
    .if_req(1'b1), .if_addr(16'h0000), .if_rdata(s_if_rdata),
    .if_done(s_if_done), .stall_if(s_stall_if),
    .mem_req(1'b1), .mem_we(1'b0), .mem_addr(16'h0004),
    .mem_wdata(16'h0000), .mem_rdata(s_mem_rdata), .mem_done(s_mem_done),
    .stall_mem(s_stall_mem),
    .ram_en(s_ram_en), .ram_we(s_ram_we), .ram_addr(s_ram_addr),
    .ram_wdata(s_ram_wdata), .ram_rdata(16'h0000),
    .conflict_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents: unwritten words read as a hash of their address.
  logic [15:0] ram_arr [int];
  logic [15:0] shadow  [int];

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] sh_rd(input logic [15:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : dflt(a);
  endfunction

  // Memory model: read data valid exactly L cycles after ram_en, noise otherwise.
  int          ram_cyc  = 0;
  int          rd_ready = -1;
  logic [15:0] rd_val   = 16'h0;

  always @(posedge clk) begin
    #2;
    ram_cyc++;
    if (ram_en) begin
      if (ram_we) begin
        ram_arr[int'(ram_addr)] = ram_wdata;
      end else begin
        rd_ready = ram_cyc + L;
        rd_val   = ram_arr.exists(int'(ram_addr)) ? ram_arr[int'(ram_addr)] : dflt(ram_addr);
      end
    end
    ram_rdata = (ram_cyc == rd_ready) ? rd_val : 16'($urandom);
  end

  // Reference model: an access sampled in cycle n issues in n+1, completes
  // in n+2+L and the arbiter is free to sample again in n+3+L.
  int          cyc     = 0;
  int          m_next  = 0;
  int          m_issue = -1;
  int          m_done  = -1;
  logic        m_last_mem = 1'b0;
  logic        m_win   = 1'b0;
  logic        m_we    = 1'b0;
  logic [15:0] m_addr  = 16'h0;
  logic [15:0] m_wdata = 16'h0;
  logic [15:0] m_if_rd = 16'h0;
  logic [15:0] m_mem_rd = 16'h0;
  logic [15:0] m_cnt   = 16'h0;
  logic [15:0] m_pend  = 16'h0;
  logic        e_en, e_if_done, e_mem_done, if_ok;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk1 ("rst ram_en", ram_en, 1'b0);
      chk1 ("rst ram_we", ram_we, 1'b0);
      chk16("rst ram_addr", ram_addr, 16'h0);
      chk16("rst ram_wdata", ram_wdata, 16'h0);
      chk16("rst if_rdata", if_rdata, 16'h0);
      chk16("rst mem_rdata", mem_rdata, 16'h0);
      chk1 ("rst if_done", if_done, 1'b0);
      chk1 ("rst mem_done", mem_done, 1'b0);
      chk16("rst conflict_cnt", conflict_cnt, 16'h0);
      chk1 ("rst stall_if", stall_if, if_req);
      chk1 ("rst stall_mem", stall_mem, mem_req);
      m_next = 0; m_issue = -1; m_done = -1;
      m_last_mem = 1'b0; m_win = 1'b0; m_we = 1'b0;
      m_addr = 16'h0; m_wdata = 16'h0; m_if_rd = 16'h0; m_mem_rd = 16'h0; m_cnt = 16'h0;
    end else begin
      e_en       = (cyc == m_issue);
      e_if_done  = (cyc == m_done) && !m_win;
      e_mem_done = (cyc == m_done) && m_win;
      if (e_if_done) m_if_rd = m_pend;
      if (e_mem_done && !m_we) m_mem_rd = m_pend;

      chk1 ("ram_en", ram_en, e_en);
      if (e_en) chk1("ram_we", ram_we, m_we);
      chk16("ram_addr", ram_addr, m_addr);
      chk16("ram_wdata", ram_wdata, m_wdata);
      chk1 ("if_done", if_done, e_if_done);
      chk1 ("mem_done", mem_done, e_mem_done);
      chk16("if_rdata", if_rdata, m_if_rd);
      chk16("mem_rdata", mem_rdata, m_mem_rd);
      chk1 ("stall_if", stall_if, if_req && !e_if_done);
      chk1 ("stall_mem", stall_mem, mem_req && !e_mem_done);
      chk16("conflict_cnt", conflict_cnt, m_cnt);

      if_ok = if_req && !hlt;
      if (if_ok && !e_if_done && mem_req && !e_mem_done && m_cnt != 16'hFFFF) m_cnt++;

      if (cyc >= m_next && (if_ok || mem_req)) begin
        m_win      = mem_req && !(if_ok && m_last_mem);
        m_last_mem = m_win;
        m_issue    = cyc + 1;
        m_done     = cyc + 2 + L;
        m_next     = cyc + 3 + L;
        if (m_win) begin
          m_addr  = mem_addr;
          m_we    = mem_we;
          m_wdata = mem_wdata;
          if (mem_we) shadow[int'(mem_addr)] = mem_wdata;
          else        m_pend = sh_rd(mem_addr);
        end else begin
          m_addr = if_addr;
          m_we   = 1'b0;
          m_pend = sh_rd(if_addr);
        end
      end
    end
  end

  // Saturation instance: both always pending, DONE every 18th cycle
  // (offset 17), so the count after k cycles is k - k/18, clamped.
  int k2 = 0;
  int exp2;
  always @(negedge clk) begin
    if (rst2_n) begin
      exp2 = k2 - k2 / 18;
      if (exp2 > 65535) exp2 = 65535;
      chk16("sat conflict_cnt", s_cnt, 16'(exp2));
      k2++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic if_busy, mem_busy, sif, smem;
  int   b;

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0; hlt = 1'b0;
    if_req = 1'b0; if_addr = 16'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 16'h0; mem_wdata = 16'h0;
    ram_rdata = 16'h0;
    ram_arr[32'h0010] = 16'hB123;
    shadow[32'h0010]  = 16'hB123;
    repeat (2) @(negedge clk);
    step(); rst_n = 1'b1; rst2_n = 1'b1;

    // IF read of 0x0010
    step(); if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk); chk1("t1 stall_if n", stall_if, 1'b1); chk1("t1 ram_en n", ram_en, 1'b0);
    @(negedge clk); chk1("t1 ram_en n+1", ram_en, 1'b1);
    chk16("t1 ram_addr", ram_addr, 16'h0010); chk1("t1 ram_we", ram_we, 1'b0);
    repeat (2) begin
      @(negedge clk); chk1("t1 ram_en wait", ram_en, 1'b0);
      chk1("t1 stall_if wait", stall_if, 1'b1); chk1("t1 if_done early", if_done, 1'b0);
    end
    @(negedge clk); chk1("t1 if_done n+4", if_done, 1'b1);
    chk16("t1 if_rdata", if_rdata, 16'hB123); chk1("t1 stall_if n+4", stall_if, 1'b0);
    step(); if_req = 1'b0;
    @(negedge clk); chk1("t1 if_done one pulse", if_done, 1'b0);

    // Store 0x5A5A to 0x8000
    step(); mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'h5A5A;
    @(negedge clk);
    @(negedge clk); chk1("t2 ram_en", ram_en, 1'b1); chk1("t2 ram_we", ram_we, 1'b1);
    chk16("t2 ram_addr", ram_addr, 16'h8000); chk16("t2 ram_wdata", ram_wdata, 16'h5A5A);
    repeat (2) @(negedge clk);
    @(negedge clk); chk1("t2 mem_done n+4", mem_done, 1'b1);
    chk1("t2 if_done", if_done, 1'b0); chk16("t2 mem_rdata kept", mem_rdata, 16'h0000);
    step(); mem_req = 1'b0; mem_we = 1'b0;

    // Contention from a fresh reset: grants MEM, IF, MEM, IF at 1, 6, 11, 16
    step(); rst_n = 1'b0;
    if_req = 1'b1; if_addr = 16'h0100; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0200;
    @(negedge clk);
    step(); rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk1("t3 ram_en slot", ram_en, (k % 5) == 1);
      if ((k % 5) == 1) chk16("t3 grant addr", ram_addr, ((k / 5) % 2 == 0) ? 16'h0200 : 16'h0100);
      if (k == 5)  chk16("t3 cnt@5", conflict_cnt, 16'd4);
      if (k == 10) chk16("t3 cnt@10", conflict_cnt, 16'd8);
    end
    step(); if_req = 1'b0; mem_req = 1'b0;

    // Halt blocks IF; halt raised mid-access still completes
    step(); hlt = 1'b1; if_req = 1'b1; if_addr = 16'h0010;
    repeat (10) begin @(negedge clk); chk1("t4 halted ram_en", ram_en, 1'b0); end
    step(); hlt = 1'b0;
    b = 0;
    do begin @(negedge clk); b++; end while (!ram_en && b < 10);
    chk1("t4 grant after unhalt", ram_en, 1'b1);
    step(); hlt = 1'b1;
    b = 0;
    do begin @(negedge clk); b++; end while (!if_done && b < 10);
    chk1("t4 if_done under halt", if_done, 1'b1);
    chk16("t4 if_rdata", if_rdata, 16'hB123);
    step(); if_req = 1'b0; hlt = 1'b0;

    // Reset in the middle of WAIT
    step(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0010;
    step();
    step(); rst_n = 1'b0;
    #1;
    chk16("t5 async ram_addr", ram_addr, 16'h0000);
    chk16("t5 async if_rdata", if_rdata, 16'h0000);
    step(); mem_req = 1'b0; rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk); chk1("t5 no mem_done", mem_done, 1'b0); chk1("t5 no ram_en", ram_en, 1'b0);
    end
    step(); if_req = 1'b1; if_addr = 16'h0010;
    b = 0;
    do begin @(negedge clk); b++; end while (!if_done && b < 10);
    chk1("t5 restart if_done", if_done, 1'b1);
    chk16("t5 restart if_rdata", if_rdata, 16'hB123);
    step(); if_req = 1'b0;

    // Randomized protocol-respecting traffic
    if_busy = 1'b0; mem_busy = 1'b0;
    while (k2 < 70000) begin
      @(negedge clk); sif = if_done; smem = mem_done;
      step();
      if (if_busy && sif)  if_busy = 1'b0;
      if (mem_busy && smem) mem_busy = 1'b0;
      if (!if_busy) begin
        if ($urandom_range(0, 3) == 0) begin
          if_busy = 1'b1; if_req = 1'b1; if_addr = 16'($urandom_range(0, 31));
        end else begin
          if_req = 1'b0;
        end
      end
      if (!mem_busy) begin
        if ($urandom_range(0, 2) == 0) begin
          mem_busy = 1'b1; mem_req = 1'b1; mem_we = 1'($urandom_range(0, 1));
          mem_addr = 16'($urandom_range(0, 31)); mem_wdata = 16'($urandom);
        end else begin
          mem_req = 1'b0;
        end
      end
      if ($urandom_range(0, 19) == 0) hlt = ~hlt;
    end

    chk16("sat final", s_cnt, 16'hFFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
